// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and helpers for the I2S playback serializer
package i2s_pkg;
    localparam int DEF_DATA_W        = 24;
    localparam int DEF_SLOT_W        = 32;
    localparam int DEF_MCLK_PER_BCLK = 4;
    localparam int DEF_FRAME_CYC     = 2 * DEF_SLOT_W * DEF_MCLK_PER_BCLK;
    localparam int DEF_CNT_W         = $clog2(DEF_FRAME_CYC);

    // Slot position 0 is the one-BCLK I2S delay; the sample MSB follows at position 1.
    localparam int SLOT_POS_DELAY = 0;
    localparam int SLOT_POS_MSB   = 1;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - frame counter producing bclk/lrck pins and bit/frame strobes
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int SLOT_W        = DEF_SLOT_W,
    parameter int MCLK_PER_BCLK = DEF_MCLK_PER_BCLK,
    localparam int POS_W        = clog2_min1(SLOT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             bclk,
    output logic             lrck,
    output logic             bit_start,
    output logic             frame_wrap,
    output logic             slot_right,
    output logic [POS_W-1:0] slot_pos
);
    localparam int PH_W  = clog2_min1(MCLK_PER_BCLK);
    localparam int BIT_W = clog2_min1(2 * SLOT_W);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(MCLK_PER_BCLK - 1);
    localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(MCLK_PER_BCLK / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SLOT_W);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0] bit_q, bit_d;

    // Strobes describe the counter value about to be entered, so registered pins line up with it.
    always_comb begin
        phase_d    = phase_q + PH_W'(1);
        bit_d      = bit_q;
        bit_start  = 1'b0;
        frame_wrap = 1'b0;
        if (phase_q == PH_LAST) begin
            phase_d   = '0;
            bit_start = 1'b1;
            if (bit_q == BIT_LAST) begin
                bit_d      = '0;
                frame_wrap = 1'b1;
            end else begin
                bit_d = bit_q + BIT_W'(1);
            end
        end
        slot_right = (bit_d >= BIT_RIGHT);
        slot_pos   = slot_right ? POS_W'(bit_d - BIT_RIGHT) : POS_W'(bit_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            bit_q   <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            bclk    <= (phase_d >= PH_HIGH);
            lrck    <= slot_right;
        end
    end
endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S master serializer; I2S_TX_UNDERRUN_CNT_EN adds underrun_cnt
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int SLOT_W        = DEF_SLOT_W,
    parameter int MCLK_PER_BCLK = DEF_MCLK_PER_BCLK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              clear,
    output logic              bclk,
    output logic              lrck,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);
    localparam int POS_W = clog2_min1(SLOT_W);
    localparam logic [POS_W-1:0] POS_MSB = POS_W'(SLOT_POS_MSB);
    localparam logic [POS_W-1:0] POS_LSB = POS_W'(DATA_W);

    logic              bit_start, frame_wrap, slot_right, in_data;
    logic [POS_W-1:0]  slot_pos;
    logic              hold_full, hold_full_d, primed, accept, underrun_evt;
    logic [DATA_W-1:0] hold_l, hold_r, left_sh, right_sh;

    i2s_clk_gen #(
        .SLOT_W        (SLOT_W),
        .MCLK_PER_BCLK (MCLK_PER_BCLK)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .bclk       (bclk),
        .lrck       (lrck),
        .bit_start  (bit_start),
        .frame_wrap (frame_wrap),
        .slot_right (slot_right),
        .slot_pos   (slot_pos)
    );

    assign accept       = s_valid && s_ready;
    assign underrun_evt = frame_wrap && !hold_full && primed;
    assign in_data      = (slot_pos >= POS_MSB) && (slot_pos <= POS_LSB);

    // A sample accepted on the wrap cycle lands in hold and waits for the next frame.
    always_comb begin
        hold_full_d = hold_full;
        if (frame_wrap && hold_full) hold_full_d = 1'b0;
        if (accept)                  hold_full_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            s_ready   <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else begin
            hold_full <= hold_full_d;
            s_ready   <= !hold_full_d;
            if (accept) begin
                hold_l <= s_left;
                hold_r <= s_right;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_sh     <= '0;
            right_sh    <= '0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            primed      <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                left_sh  <= hold_full ? hold_l : '0;
                right_sh <= hold_full ? hold_r : '0;
                if (hold_full) primed <= 1'b1;
            end else if (bit_start && in_data) begin
                if (slot_right) right_sh <= right_sh << 1;
                else            left_sh  <= left_sh << 1;
            end
            if (bit_start)
                sdata <= in_data ? (slot_right ? right_sh[DATA_W-1] : left_sh[DATA_W-1]) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            underrun <= 1'b0;
        else if (clear)        underrun <= 1'b0;
        else if (underrun_evt) underrun <= 1'b1;
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      underrun_cnt <= '0;
        else if (clear)                                  underrun_cnt <= '0;
        else if (underrun_evt && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - directed self-checking bench for i2s_tx_serializer
module tb_i2s_tx_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] s_left = '0, s_right = '0;
    logic        s_valid = 1'b0, clear = 1'b0;
    logic        s_ready, bclk, lrck, sdata, frame_start, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;
    vec_t vec [100];

    i2s_tx_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .clear       (clear),
        .bclk        (bclk),
        .lrck        (lrck),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame_start();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        check("sync_frame_start", found, 1'b1);
    endtask

    // Entered on the negedge where frame_start is high (c=0); returns on the next frame's c=0.
    task automatic capture(input logic [31:0] exp_l, input logic [31:0] exp_r, input logic exp_ur,
                           input logic do_send, input logic [23:0] nl, input logic [23:0] nr);
        logic [31:0] got_l, got_r;
        int shape_err, k, ph;
        got_l = '0;
        got_r = '0;
        shape_err = 0;
        check("frame_start", frame_start, 1'b1);
        check("underrun_at_frame", underrun, exp_ur);
        for (int c = 0; c < 256; c++) begin
            k  = c / 4;
            ph = c % 4;
            if (bclk !== (ph >= 2)) shape_err++;
            if (lrck !== (k >= 32)) shape_err++;
            if (c > 0 && frame_start) shape_err++;
            if (ph == 2) begin
                if (k < 32) got_l = {got_l[30:0], sdata};
                else        got_r = {got_r[30:0], sdata};
            end
            if (do_send && c == 4) begin
                check("s_ready_in_frame", s_ready, 1'b1);
                s_left  = nl;
                s_right = nr;
                s_valid = 1'b1;
            end
            if (c == 5) s_valid = 1'b0;
            @(negedge clk);
        end
        check("left_slot", got_l, exp_l);
        check("right_slot", got_r, exp_r);
        check("bclk_lrck_shape", shape_err, 0);
    endtask

    initial begin
        int n;
        vec[0] = '{24'hA5A5A5, 24'h5A5A5A, 32'h52D2D280, 32'h2D2D2D00};
        vec[1] = '{24'hFFFFFF, 24'h000000, 32'h7FFFFF80, 32'h00000000};
        vec[2] = '{24'h800000, 24'h7FFFFF, 32'h40000000, 32'h3FFFFF80};
        vec[3] = '{24'h000001, 24'hFFFFFE, 32'h00000080, 32'h7FFFFF00};
        vec[4] = '{24'h123456, 24'hABCDEF, 32'h091A2B00, 32'h55E6F780};
        vec[5] = '{24'h000000, 24'hFFFFFF, 32'h00000000, 32'h7FFFFF80};
        vec[6] = '{24'h555555, 24'hAAAAAA, 32'h2AAAAA80, 32'h55555500};
        vec[7] = '{24'hC0FFEE, 24'h000F0F, 32'h607FF700, 32'h00078780};
        for (int i = 8; i < 100; i++) begin
            vec[i].l     = 24'(i * 32'h00C3A5 + 32'h13579B);
            vec[i].r     = ~vec[i].l ^ 24'(i);
            vec[i].exp_l = {1'b0, vec[i].l, 7'b0};
            vec[i].exp_r = {1'b0, vec[i].r, 7'b0};
        end

        // Reset state and release
        repeat (3) @(negedge clk);
        check("reset_pins", {bclk, lrck, sdata, frame_start, underrun, s_ready}, 6'b0);
        rst_n = 1'b1;
        check("s_ready_before_first_clk", s_ready, 1'b0);
        @(negedge clk);
        check("s_ready_after_release", s_ready, 1'b1);

        // Pre-prime zero frames, then stream 100 pairs back to back
        wait_frame_start();
        capture(32'h0, 32'h0, 1'b0, 1'b0, 24'h0, 24'h0);
        capture(32'h0, 32'h0, 1'b0, 1'b0, 24'h0, 24'h0);
        capture(32'h0, 32'h0, 1'b0, 1'b1, vec[0].l, vec[0].r);
        for (int i = 0; i < 100; i++) begin
            if (i < 99) capture(vec[i].exp_l, vec[i].exp_r, 1'b0, 1'b1, vec[i+1].l, vec[i+1].r);
            else        capture(vec[i].exp_l, vec[i].exp_r, 1'b0, 1'b0, 24'h0, 24'h0);
        end

        // Starved frame after priming, then clear
        capture(32'h0, 32'h0, 1'b1, 1'b0, 24'h0, 24'h0);
        check("underrun_sticky", underrun, 1'b1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_cnt_two", underrun_cnt, 16'd2);
`endif
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("underrun_cleared", underrun, 1'b0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_cnt_cleared", underrun_cnt, 16'd0);
`endif

        // Sample offered exactly on the wrap cycle with hold empty
        repeat (254) @(negedge clk);
        check("s_ready_before_wrap", s_ready, 1'b1);
        s_left  = 24'h0F0F0F;
        s_right = 24'hF0F0F0;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check("underrun_on_wrap_accept", underrun, 1'b1);
        check("s_ready_after_wrap_accept", s_ready, 1'b0);
        capture(32'h0, 32'h0, 1'b1, 1'b0, 24'h0, 24'h0);
        capture(32'h07878780, 32'h78787800, 1'b1, 1'b0, 24'h0, 24'h0);

        // Reset mid-frame with a sample in flight
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 4) begin
                s_left  = 24'h7E57AB;
                s_right = 24'h1CEB00;
                s_valid = 1'b1;
            end
            if (c == 5) s_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("async_reset_pins", {bclk, lrck, sdata, frame_start, underrun, s_ready}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (frame_start) begin
                n = i;
                break;
            end
        end
        check("reset_to_first_frame", n, 256);
        capture(32'h0, 32'h0, 1'b0, 1'b0, 24'h0, 24'h0);
        check("no_underrun_after_reset", underrun, 1'b0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_cnt_after_reset", underrun_cnt, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
